// File: rtl/data_table_rd_arbiter_pkg.sv
// data_table_rd_arbiter_pkg: table geometry and engine index types shared by the read arbiter and the engines
package data_table_rd_arbiter_pkg;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int RAM_DATA_WIDTH = 32;
  localparam int ENGINES_CNT_DEF = 3;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ENGINE_IDX_WIDTH = idx_width(ENGINES_CNT_DEF);
  typedef logic [RAM_DATA_WIDTH-1:0] ram_data_t;
  typedef logic [ENGINE_IDX_WIDTH-1:0] engine_idx_t;
endpackage

// File: rtl/data_table_rd_arbiter_if.sv
// data_table_rd_arbiter_if: engine-side request/grant/return bus plus the RAM read port
//  slave  = arbiter view: takes req/req_addr/ram_rd_data, drives gnt/rd_data_val/rd_data/ram_rd_*
//  master = engine array and RAM view
interface data_table_rd_arbiter_if
  import data_table_rd_arbiter_pkg::*;
#(
  parameter int ENGINES_CNT = ENGINES_CNT_DEF,
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
);
  logic [ENGINES_CNT-1:0] req;
  logic [ENGINES_CNT-1:0][A_WIDTH-1:0] req_addr;
  logic [ENGINES_CNT-1:0] gnt;
  logic [ENGINES_CNT-1:0] rd_data_val;
  ram_data_t rd_data;
  logic [A_WIDTH-1:0] ram_rd_addr;
  logic ram_rd_en;
  ram_data_t ram_rd_data;
  modport slave (
    input  req, req_addr, ram_rd_data,
    output gnt, rd_data_val, rd_data, ram_rd_addr, ram_rd_en
  );
  modport master (
    output req, req_addr, ram_rd_data,
    input  gnt, rd_data_val, rd_data, ram_rd_addr, ram_rd_en
  );
endinterface

// File: rtl/data_table_rd_arbiter_rr_arbiter.sv
// rr_arbiter: work-conserving round-robin pick of one requester, searching upward from a rotating pointer
//  clk_i, rst_i  clock, async active-high reset (pointer -> 0)
//  en            grants allowed this cycle
//  req           per-requester request
//  gnt, idx, val one-hot grant, its index, any grant (all combinational)
module rr_arbiter #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic         val
);
  logic [IW-1:0] ptr;
  // Walk offsets from farthest to nearest so the nearest requester above the pointer wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
  end
  assign val = |gnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr <= '0;
    else if (val) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/data_table_rd_arbiter.sv
// data_table_rd_arbiter: round-robin sharing of the data table RAM read port between engines
//  clk_i, rst_i  clock, async active-high reset (drops every in-flight read)
//  pause_i       1 = no new grants; issued reads still complete
//  bus           engine req/addr -> gnt, per-engine rd_data_val, broadcast rd_data; RAM rd port
//  busy_o        a read is being issued or is in flight
module data_table_rd_arbiter
  import data_table_rd_arbiter_pkg::*;
#(
  parameter int ENGINES_CNT = ENGINES_CNT_DEF,
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pause_i,
  data_table_rd_arbiter_if.slave bus,
  output logic busy_o
);
  localparam int IW = idx_width(ENGINES_CNT);
  logic gnt_val;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] iss_idx;
  logic [RAM_LATENCY-1:0] pipe_val;
  logic [IW-1:0] pipe_idx [RAM_LATENCY];
  // Grants are suppressed while reset is held so gnt reads 0 during reset.
  rr_arbiter #(.N(ENGINES_CNT), .IW(IW)) u_rr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(!pause_i && !rst_i),
    .req(bus.req),
    .gnt(bus.gnt),
    .idx(gnt_idx),
    .val(gnt_val)
  );
  // Issue stage, then a RAM_LATENCY deep tag pipeline aligned with the RAM data return.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.ram_rd_en <= 1'b0;
      bus.ram_rd_addr <= '0;
      iss_idx <= '0;
      pipe_val <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) pipe_idx[s] <= '0;
    end else begin
      bus.ram_rd_en <= gnt_val;
      if (gnt_val) begin
        bus.ram_rd_addr <= bus.req_addr[gnt_idx];
        iss_idx <= gnt_idx;
      end
      for (int s = RAM_LATENCY - 1; s > 0; s--) begin
        pipe_val[s] <= pipe_val[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
      pipe_val[0] <= bus.ram_rd_en;
      pipe_idx[0] <= iss_idx;
    end
  assign bus.rd_data_val = pipe_val[RAM_LATENCY-1] ? ENGINES_CNT'(1) << pipe_idx[RAM_LATENCY-1] : '0;
  assign bus.rd_data = bus.ram_rd_data;
  assign busy_o = bus.ram_rd_en | (|pipe_val);
endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// tb_data_table_rd_arbiter: scoreboard bench for the data table read arbiter (3 engines, latency 2)
module tb_data_table_rd_arbiter;
  typedef struct {
    int cyc;
    logic [2:0] who;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic busy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t iss_q[$];
  exp_t ret_q[$];
  logic [31:0] m0 = 32'h0;
  logic [31:0] m1 = 32'h0;
  logic [2:0] g = 3'b000;
  int waitc [3];

  data_table_rd_arbiter_if #(.ENGINES_CNT(3), .A_WIDTH(8)) bus ();

  data_table_rd_arbiter #(.ENGINES_CNT(3), .RAM_LATENCY(2), .A_WIDTH(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pause_i(pause),
    .bus(bus.slave),
    .busy_o(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f(input logic [7:0] a);
    return 32'hD000_0000 | {16'h0, a, ~a};
  endfunction

  // Two-cycle RAM: word for the address presented with ram_rd_en appears two edges later.
  always @(posedge clk) begin
    m0 <= bus.ram_rd_en ? f(bus.ram_rd_addr) : 32'hDEAD_DEAD;
    m1 <= m0;
  end
  assign bus.ram_rd_data = m1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", n, cyc, act, req);
    end
  endtask

  function automatic int oh2i(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic expect_grant(input logic [2:0] eg, input bit ret);
    exp_t e;
    logic [7:0] a;
    a = bus.req_addr[oh2i(eg)];
    e.cyc = cyc + 1;
    e.who = eg;
    e.data = {24'h0, a};
    iss_q.push_back(e);
    if (ret) begin
      e.cyc = cyc + 3;
      e.data = f(a);
      ret_q.push_back(e);
    end
  endtask

  task automatic step(input logic [2:0] r, input logic p, input logic [2:0] eg, input bit ret, input int eb);
    @(posedge clk);
    #1;
    bus.req = r;
    pause = p;
    @(negedge clk);
    chk("gnt", bus.gnt, eg);
    if (eb >= 0) chk("busy", busy, eb[0]);
    if (eg != 0) expect_grant(eg, ret);
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'b000, 1'b0, 3'b000, 1'b1, -1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        e = iss_q.pop_front();
        chk("issue_missing", 0, 1);
      end
      while (ret_q.size() > 0 && ret_q[0].cyc < cyc) begin
        e = ret_q.pop_front();
        chk("return_missing", 0, 1);
      end
      if (bus.ram_rd_en) begin
        if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          e = iss_q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_addr", bus.ram_rd_addr, e.data);
        end
      end
      if (bus.rd_data_val != 0) begin
        if (ret_q.size() == 0) chk("return_unexpected", bus.rd_data_val, 0);
        else begin
          e = ret_q.pop_front();
          chk("return_cycle", cyc, e.cyc);
          chk("return_val", bus.rd_data_val, e.who);
          chk("return_data", bus.rd_data, e.data);
        end
      end
    end
  end

  initial begin
    bus.req = 3'b111;
    bus.req_addr[0] = 8'h0A;
    bus.req_addr[1] = 8'h15;
    bus.req_addr[2] = 8'h2C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", bus.gnt, 0);
    chk("reset_en", bus.ram_rd_en, 0);
    chk("reset_addr", bus.ram_rd_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_val", bus.rd_data_val, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 3'b000;
    // single read by engine 1, pointer 0 -> 2
    step(3'b010, 1'b0, 3'b010, 1'b1, 0);
    step(3'b000, 1'b0, 3'b000, 1'b1, 1);
    idle(4);
    // wrap from pointer 2 to engine 0, then skip engine 1 to reach engine 2
    step(3'b001, 1'b0, 3'b001, 1'b1, -1);
    step(3'b101, 1'b0, 3'b100, 1'b1, -1);
    idle(4);
    // pause holds grants while the two issued reads drain
    step(3'b111, 1'b0, 3'b001, 1'b1, -1);
    step(3'b111, 1'b0, 3'b010, 1'b1, -1);
    step(3'b111, 1'b1, 3'b000, 1'b1, 1);
    step(3'b111, 1'b1, 3'b000, 1'b1, 1);
    step(3'b111, 1'b1, 3'b000, 1'b1, 1);
    step(3'b111, 1'b1, 3'b000, 1'b1, 0);
    step(3'b111, 1'b0, 3'b100, 1'b1, -1);
    idle(4);
    // reset one cycle after the read issues: its return is dropped
    step(3'b001, 1'b0, 3'b001, 1'b0, -1);
    step(3'b000, 1'b0, 3'b000, 1'b0, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req = 3'b011;
    @(negedge clk);
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_en", bus.ram_rd_en, 0);
    chk("midrst_addr", bus.ram_rd_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_val", bus.rd_data_val, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 3'b000;
    idle(4);
    // pointer must be back at 0 (a kept pointer of 1 would pick engine 1)
    step(3'b011, 1'b0, 3'b001, 1'b1, -1);
    // fairness with everyone requesting, pointer now 1
    step(3'b111, 1'b0, 3'b010, 1'b1, -1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 1);
    step(3'b111, 1'b0, 3'b001, 1'b1, 1);
    step(3'b111, 1'b0, 3'b010, 1'b1, 1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 1);
    step(3'b111, 1'b0, 3'b001, 1'b1, 1);
    idle(5);
    // random engines: hold req until granted, drop it the next cycle
    for (int i = 0; i < 3; i++) waitc[i] = 0;
    g = 3'b000;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (g[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_addr[i] = 8'($urandom);
        end
      pause = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      g = bus.gnt;
      chk("rnd_onehot", {63'h0, $onehot0(g)}, 1);
      chk("rnd_subset", g & ~bus.req, 0);
      chk("rnd_conserve", {63'h0, g != 0}, {63'h0, !pause && bus.req != 0});
      if (g != 0) begin
        for (int i = 0; i < 3; i++)
          if (g[i]) begin
            chk("rnd_wait", {63'h0, waitc[i] < 3}, 1);
            waitc[i] = 0;
          end else if (bus.req[i]) waitc[i]++;
        expect_grant(g, 1'b1);
      end
    end
    idle(6);
    chk("issue_queue_empty", iss_q.size(), 0);
    chk("return_queue_empty", ret_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
